line_memory_responder: RTL and testbench
========================================

Name: line_memory_responder

Overview:
- Line-granular, multi-cycle backing-memory responder.
- Serves cache-miss refills and dirty write-backs issued by the cache controller over the line-memory request/response handshake.
- Accepts one request at a time, models a fixed access latency, and returns a full line on reads.
- Also keeps read/write request counters for performance accounting in the pipeline testbench.

Parameters:
- BLOCK_SIZE, 16, line size in bytes; line data width is BLOCK_SIZE*8 bits.
- NUM_LINES, 256, number of lines stored; index width is CLOG2(NUM_LINES).
- LATENCY, 50, cycles from request acceptance to completion; legal range is 1 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- is_input_valid  input  1  a request is presented this cycle.
- addr  input  32  line address (byte address already shifted by CLOG2(BLOCK_SIZE)).
- mem_read  input  1  request is a line read.
- mem_write  input  1  request is a line write.
- din  input  BLOCK_SIZE*8  write line data.
- is_output_valid  output  1  dout holds read data; one-cycle pulse.
- dout  output  BLOCK_SIZE*8  read line data.
- mem_ready  output  1  responder can accept a request this cycle.
- num_reads  output  32  count of accepted read requests.
- num_writes  output  32  count of accepted write requests.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0, is_output_valid=0, dout=0, num_reads=0, num_writes=0, latched request cleared.
  - mem_ready is 1 once reset deasserts.
  - Array contents are not cleared by reset; the bench initialises them via hierarchical preload.
- States:
  - IDLE: mem_ready=1.
  - BUSY: mem_ready=0; counting down the latency.
  - RESP: mem_ready=0, is_output_valid=1.
  - mem_ready and is_output_valid are decoded from state and registered-output clean.
- Accept:
  - A request is accepted on an edge in IDLE when is_input_valid=1 and exactly one of mem_read/mem_write is 1.
  - On acceptance, latch index=addr[CLOG2(NUM_LINES)-1:0], the op, and din; load counter=LATENCY-1; go to BUSY.
  - On acceptance, increment num_reads or num_writes by 1. Counters wrap modulo 2^32.
- Ignored requests:
  - is_input_valid=1 with both mem_read and mem_write at 0, or both at 1: ignored. No state change, no counter change.
  - Any request presented while not in IDLE: ignored, with no queueing. The initiator must hold or re-present it.
- Address bits above the index are ignored, so the array aliases.
- BUSY:
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0:
    - read: load dout from array[index]; go to RESP.
    - write: array[index]<=latched din; go to IDLE. No output pulse for writes.
- RESP: lasts exactly one cycle, then IDLE. dout holds its value after the pulse until the next read completes.
- Timing: a request accepted at edge E0 sees:
  - read: is_output_valid=1 during the cycle following edge E0+LATENCY; mem_ready=1 again after edge E0+LATENCY+1.
  - write: commit at edge E0+LATENCY; mem_ready=1 after that edge.
  - Back-to-back reads are therefore LATENCY+1 cycles apart; back-to-back writes are LATENCY cycles apart.
- Coherence:
  - A read accepted after a write completes returns the written data.
  - din and addr changing after acceptance has no effect.
- Reset during BUSY/RESP: pending write is discarded (array untouched); any pending read pulse is cancelled; state returns to IDLE.
- LATENCY=1: accept at E0 → BUSY with counter=0 → read reaches RESP at E1.

Test Plan:
- Read, LATENCY=4: preload array[5]=128'hA5..A5; read addr=5 accepted at E0 → mem_ready=0 for 5 cycles; is_output_valid=1 exactly one cycle after E4 with dout=128'hA5..A5; num_reads=1.
- Write then read: write addr=0x103 din=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 → no output pulse; mem_ready returns after 4 cycles; read addr=3 (aliased index) returns the same line; num_writes=1, num_reads=1.
- Illegal and busy requests:
  - mem_read=1 and mem_write=1 in IDLE → stays IDLE, counters unchanged.
  - A read presented mid-BUSY → ignored; only the first request completes.
- Reset mid-write: assert reset two cycles after accepting a write to addr 7 → outputs go to reset values immediately; array[7] keeps its old value.
- LATENCY=1 stress: 100 random legal requests with is_input_valid held high → each read response matches a reference model; read spacing is 2 cycles, write spacing is 1 cycle; final num_reads+num_writes=100.

Source files
------------

// File: rtl/line_memory_responder.sv
// ----------------------------------------------------------------------------
// line_memory_responder
//
// Line-granular backing memory for the cache controller. It takes one refill
// (read) or write-back (write) request at a time, waits a fixed access
// latency and then either returns the line (read) or commits it (write).
// It also counts accepted reads and writes for performance accounting.
//
// Handshake: a request is taken on a rising edge where mem_ready=1,
// is_input_valid=1 and exactly one of mem_read/mem_write is 1. Anything
// presented while mem_ready=0, or with an illegal op mix, is dropped (no
// queueing); the initiator re-presents it. A read answers with a single-cycle
// is_output_valid pulse carrying dout; a write produces no response.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   is_input_valid  request present
//   addr            line address; only the low CLOG2(NUM_LINES) bits are used
//   mem_read        request is a line read
//   mem_write       request is a line write
//   din             write line data
//   is_output_valid read data valid (one-cycle pulse)
//   dout            read line data, held until the next read completes
//   mem_ready       idle and able to accept a request
//   num_reads       accepted reads (wraps modulo 2^32)
//   num_writes      accepted writes (wraps modulo 2^32)
// ----------------------------------------------------------------------------
module line_memory_responder #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 256,  // power of two; upper address bits alias
  parameter int LATENCY    = 50    // 1 or more
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready,
  output logic [31:0]             num_reads,
  output logic [31:0]             num_writes
);

  localparam int W     = BLOCK_SIZE * 8;
  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [IDX_W-1:0] idx_q;
  logic             op_write_q;
  logic [W-1:0]     wdata_q;
  logic             accept;
  logic             commit_write;

  // Line storage; deliberately not reset.
  logic [W-1:0] mem [NUM_LINES];

  // Address bits above the index are don't-care (the array aliases).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:IDX_W];

  assign accept = (state == IDLE) && is_input_valid && (mem_read ^ mem_write);

  // Write commit is decoded from registered state only, so an asynchronous
  // reset (which forces IDLE) discards a pending write before the next edge.
  assign commit_write = (state == BUSY) && (counter == '0) && op_write_q;

  // Handshake outputs are pure state decodes.
  assign mem_ready       = (state == IDLE);
  assign is_output_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      dout       <= '0;
      num_reads  <= '0;
      num_writes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q      <= addr[IDX_W-1:0];
            op_write_q <= mem_write;
            wdata_q    <= din;
            counter    <= CNT_LOAD;
            state      <= BUSY;
            if (mem_write) num_writes <= num_writes + 32'd1;
            else           num_reads  <= num_reads + 32'd1;
          end
        end
        BUSY: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else if (op_write_q) begin
            state <= IDLE;
          end else begin
            dout  <= mem[idx_q];
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// ----------------------------------------------------------------------------
// tb_line_memory_responder
//
// Two instances share clock and reset: dut_a with LATENCY=4 for the directed
// cases, dut_b with LATENCY=1 for the held-valid random stream. Read
// expectations are pushed into per-instance queues at issue time from a
// bench-side line model; monitors pop and compare on every output pulse.
// ----------------------------------------------------------------------------
module tb_line_memory_responder;

  localparam int W   = 128;
  localparam int LAT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // dut_a signals
  logic          a_valid, a_rd, a_wr, a_ov, a_ready;
  logic [31:0]   a_addr, a_nr, a_nw;
  logic [W-1:0]  a_din, a_dout;
  // dut_b signals
  logic          b_valid, b_rd, b_wr, b_ov, b_ready;
  logic [31:0]   b_addr, b_nr, b_nw;
  logic [W-1:0]  b_din, b_dout;

  line_memory_responder #(.BLOCK_SIZE(16), .NUM_LINES(256), .LATENCY(LAT)) dut_a (
    .clk(clk), .reset(reset), .is_input_valid(a_valid), .addr(a_addr),
    .mem_read(a_rd), .mem_write(a_wr), .din(a_din), .is_output_valid(a_ov),
    .dout(a_dout), .mem_ready(a_ready), .num_reads(a_nr), .num_writes(a_nw)
  );

  line_memory_responder #(.BLOCK_SIZE(16), .NUM_LINES(256), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .is_input_valid(b_valid), .addr(b_addr),
    .mem_read(b_rd), .mem_write(b_wr), .din(b_din), .is_output_valid(b_ov),
    .dout(b_dout), .mem_ready(b_ready), .num_reads(b_nr), .num_writes(b_nw)
  );

  // scoreboard
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] ref_a[256];
  logic [W-1:0] ref_b[256];
  logic [W-1:0] pop_a, pop_b;
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (a_ov === 1'b1) begin
      if (exp_a.size() == 0) begin
        check("a_pulse_without_read", W'(a_ov), W'(0));
      end else begin
        pop_a = exp_a.pop_front();
        check("a_read_data", a_dout, pop_a);
      end
    end
  end

  always @(negedge clk) begin
    if (b_ov === 1'b1) begin
      if (exp_b.size() == 0) begin
        check("b_pulse_without_read", W'(b_ov), W'(0));
      end else begin
        pop_b = exp_b.pop_front();
        check("b_read_data", b_dout, pop_b);
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic wait_ready_a();
    int t;
    t = 0;
    while (a_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("a_ready_timeout", W'(a_ready), W'(1));
  endtask

  task automatic issue_a(input logic rd, input logic wr, input logic [31:0] ad,
                         input logic [W-1:0] d);
    wait_ready_a();
    a_valid = 1'b1; a_rd = rd; a_wr = wr; a_addr = ad; a_din = d;
    if (rd && !wr) exp_a.push_back(ref_a[ad[7:0]]);
    if (wr && !rd) ref_a[ad[7:0]] = d;
    @(negedge clk);
    // scramble inputs after acceptance; they must have no effect
    a_valid = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
    a_addr = $urandom();
    a_din  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // issue, then check busy length and where the output pulse lands
  task automatic op_a(input string name, input logic rd, input logic [31:0] ad,
                      input logic [W-1:0] d);
    int low, vat, k;
    issue_a(rd, !rd, ad, d);
    low = 0; vat = 0; k = 1;
    while (a_ready !== 1'b1 && k < 100) begin
      low++;
      if (a_ov === 1'b1) vat = k;
      @(negedge clk);
      k++;
    end
    check({name, "_busy_cycles"}, W'(low), rd ? W'(LAT + 1) : W'(LAT));
    check({name, "_pulse_cycle"}, W'(vat), rd ? W'(LAT + 1) : W'(0));
  endtask

  // stimulus
  initial begin
    int reads, low, t;
    logic        rd;
    logic [31:0] ad;
    logic [W-1:0] d;

    reset = 1'b0;
    a_valid = 0; a_rd = 0; a_wr = 0; a_addr = 0; a_din = 0;
    b_valid = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_din = 0;

    for (int i = 0; i < 256; i++) begin
      ref_a[i] = {16{8'(i) ^ 8'h3C}};
      ref_b[i] = {16{8'(i) ^ 8'hC3}};
    end
    ref_a[5] = {16{8'hA5}};
    for (int i = 0; i < 256; i++) begin
      dut_a.mem[i] <= ref_a[i];
      dut_b.mem[i] <= ref_b[i];
    end

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_ready", W'(a_ready), W'(1));
    check("rst_valid", W'(a_ov), W'(0));
    check("rst_dout", a_dout, W'(0));
    check("rst_num_reads", W'(a_nr), W'(0));
    check("rst_num_writes", W'(a_nw), W'(0));

    // read of a preloaded line
    op_a("read5", 1'b1, 32'd5, '0);
    check("read5_num_reads", W'(a_nr), W'(1));

    // write then aliased read
    op_a("write103", 1'b0, 32'h103, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    op_a("read3", 1'b1, 32'd3, '0);
    check("wr_rd_num_writes", W'(a_nw), W'(1));
    check("wr_rd_num_reads", W'(a_nr), W'(2));
    check("read3_dout_held", a_dout, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);

    // illegal op mixes in IDLE
    a_valid = 1; a_rd = 1; a_wr = 1; a_addr = 32'd9;
    @(negedge clk);
    check("both_ops_ready", W'(a_ready), W'(1));
    a_rd = 0; a_wr = 0;
    @(negedge clk);
    check("no_op_ready", W'(a_ready), W'(1));
    a_valid = 0;
    @(negedge clk);
    check("illegal_num_reads", W'(a_nr), W'(2));
    check("illegal_num_writes", W'(a_nw), W'(1));

    // request while busy is dropped
    issue_a(1'b1, 1'b0, 32'd9, '0);
    @(negedge clk);
    a_valid = 1; a_rd = 1; a_addr = 32'd10;
    @(negedge clk);
    a_valid = 0; a_rd = 0;
    wait_ready_a();
    repeat (3) @(negedge clk);
    check("busy_drop_num_reads", W'(a_nr), W'(3));
    check("busy_drop_queue_empty", W'(exp_a.size()), W'(0));

    // reset two cycles into a write to line 7
    wait_ready_a();
    a_valid = 1; a_wr = 1; a_addr = 32'd7; a_din = {4{32'hDEAD_BEEF}};
    @(posedge clk);
    @(negedge clk);
    a_valid = 0; a_wr = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", W'(a_ready), W'(1));
    check("midrst_valid", W'(a_ov), W'(0));
    check("midrst_dout", a_dout, W'(0));
    check("midrst_num_writes", W'(a_nw), W'(0));
    check("midrst_num_reads", W'(a_nr), W'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op_a("read7_after_rst", 1'b1, 32'd7, '0);
    check("read7_num_reads", W'(a_nr), W'(1));

    // LATENCY=1 held-valid random stream
    reads = 0;
    b_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      t = 0;
      while (b_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check("b_ready_timeout", W'(b_ready), W'(1));
      rd = 1'($urandom_range(0, 1));
      ad = $urandom() & 32'hFFFF_FF07;
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_rd = rd; b_wr = !rd; b_addr = ad; b_din = d;
      if (rd) begin
        exp_b.push_back(ref_b[ad[7:0]]);
        reads++;
      end else begin
        ref_b[ad[7:0]] = d;
      end
      @(negedge clk);
      low = 0;
      while (b_ready !== 1'b1 && low < 20) begin
        low++;
        @(negedge clk);
      end
      check(rd ? "b_read_busy_cycles" : "b_write_busy_cycles", W'(low), rd ? W'(2) : W'(1));
    end
    b_valid = 1'b0; b_rd = 0; b_wr = 0;
    repeat (4) @(negedge clk);
    check("b_total_requests", W'(b_nr + b_nw), W'(100));
    check("b_num_reads", W'(b_nr), W'(reads));
    check("b_queue_empty", W'(exp_b.size()), W'(0));
    check("a_queue_empty", W'(exp_a.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
